// File: rtl/recirc_pkg.sv
// Shared encodings and types for the recirculation return stage.
package recirc_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 4;
    localparam int LANES      = 4;

    typedef enum logic [1:0] {
        SRC_IDLE   = 2'd0,
        SRC_LIVE   = 2'd1,
        SRC_REPLAY = 2'd2
    } src_t;

    typedef struct packed {
        logic [DEF_DATA_W-1:0] lane3;
        logic [DEF_DATA_W-1:0] lane2;
        logic [DEF_DATA_W-1:0] lane1;
        logic [DEF_DATA_W-1:0] lane0;
    } lane_group_t;

endpackage

// File: rtl/recirc_fifo.sv
// Synchronous FIFO of fixed-width words; full/empty come from the occupancy count.
module recirc_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_L,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // NOTE: storage is left out of reset; only pointers and count define
    // validity, so clearing the array would just add reset fanout.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/recirculacion_retorno.sv
// Return end of the recirculation loop: buffers tester groups and replays
// them into idle live-stream slots; live data always wins.
module recirculacion_retorno
    import recirc_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                    clk,
    input  logic                    reset_L,
    input  logic [DATA_W-1:0]       In0,
    input  logic [DATA_W-1:0]       In1,
    input  logic [DATA_W-1:0]       In2,
    input  logic [DATA_W-1:0]       In3,
    input  logic                    validIn,
    input  logic [DATA_W-1:0]       rec0,
    input  logic [DATA_W-1:0]       rec1,
    input  logic [DATA_W-1:0]       rec2,
    input  logic [DATA_W-1:0]       rec3,
    input  logic                    rec_valid,
    output logic                    rec_ready,
    output logic [DATA_W-1:0]       data_out0,
    output logic [DATA_W-1:0]       data_out1,
    output logic [DATA_W-1:0]       data_out2,
    output logic [DATA_W-1:0]       data_out3,
    output logic                    valid_out,
    output logic [1:0]              src,
    output logic                    fifo_full,
    output logic                    fifo_empty,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow
);

    localparam int GRP_W = LANES * DATA_W;

    logic [GRP_W-1:0] head;
    logic             push;
    logic             pop;
    src_t             src_q;

    assign rec_ready = !fifo_full;
    assign push      = rec_valid && rec_ready;
    assign pop       = !validIn && !fifo_empty;
    assign src       = src_q;

    recirc_fifo #(
        .WIDTH (GRP_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_L (reset_L),
        .push    (push),
        .din     ({rec3, rec2, rec1, rec0}),
        .pop     (pop),
        .head    (head),
        .count   (count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Selection state is the registered source; outputs follow it by one cycle.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            data_out0 <= '0;
            data_out1 <= '0;
            data_out2 <= '0;
            data_out3 <= '0;
            valid_out <= 1'b0;
            src_q     <= SRC_IDLE;
            overflow  <= 1'b0;
        end else begin
            if (validIn) begin
                data_out0 <= In0;
                data_out1 <= In1;
                data_out2 <= In2;
                data_out3 <= In3;
                valid_out <= 1'b1;
                src_q     <= SRC_LIVE;
            end else if (!fifo_empty) begin
                data_out0 <= head[0*DATA_W +: DATA_W];
                data_out1 <= head[1*DATA_W +: DATA_W];
                data_out2 <= head[2*DATA_W +: DATA_W];
                data_out3 <= head[3*DATA_W +: DATA_W];
                valid_out <= 1'b1;
                src_q     <= SRC_REPLAY;
            end else begin
                data_out0 <= '0;
                data_out1 <= '0;
                data_out2 <= '0;
                data_out3 <= '0;
                valid_out <= 1'b0;
                src_q     <= SRC_IDLE;
            end
            if (rec_valid && fifo_full) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: doc/recirculacion_retorno.md
# recirculacion_retorno

Re-injection stage that closes the recirculation loop in the 4-lane byte path. The upstream demux diverts 32-bit lane groups (4 × 8 bit) to the tester side whenever the live stream is not valid; this block is the return end. It buffers lane groups handed back from the tester in a small FIFO and replays them into the mux path in cycles where the live stream is idle. Live data always has priority.

## Interface
Parameters:
- DATA_W, 8, width of one lane
- DEPTH, 4, number of 4-lane groups held in the FIFO; must be a power of 2, minimum 2

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- reset_L  in  1  asynchronous, active-low reset
- In0..In3  in  DATA_W each  live lane data
- validIn  in  1  live lanes carry valid data this cycle
- rec0..rec3  in  DATA_W each  recirculated lane group returned by the tester
- rec_valid  in  1  rec0..rec3 hold a group offered for storage
- rec_ready  out  1  combinational; `!fifo_full`
- data_out0..data_out3  out  DATA_W each  registered merged lane data to the mux path
- valid_out  out  1  registered; data_out0..data_out3 are valid
- src  out  2  registered source of the current output: 0 idle, 1 live, 2 replay; 3 never driven
- fifo_full  out  1  count == DEPTH
- fifo_empty  out  1  count == 0
- count  out  $clog2(DEPTH)+1  groups currently stored
- overflow  out  1  sticky; set when a group is offered while full

## Operation
- Push: `rec_valid && rec_ready` stores {rec3,rec2,rec1,rec0} at the write pointer. The write pointer increments modulo DEPTH.
- Offer while full (`rec_valid && fifo_full`): the group is dropped, no state changes except `overflow <= 1`. overflow clears only on reset.
- Output selection, evaluated every cycle:
  - LIVE when validIn=1. Registers In0..In3, sets valid_out=1 and src=1. The FIFO is not popped.
  - REPLAY when validIn=0 and the FIFO is not empty. Registers the FIFO head, sets valid_out=1 and src=2, pops, and the read pointer increments modulo DEPTH.
  - IDLE when validIn=0 and the FIFO is empty. data_out* = 0, valid_out=0, src=0.
- Simultaneous push and pop in the same cycle: both take effect and count is unchanged. rec_ready depends only on the current count, so a full FIFO refuses a push even when a pop happens in the same cycle.
- No bypass: a group pushed into an empty FIFO can be replayed no earlier than the next cycle.
- count arithmetic: +1 on push only, −1 on pop only, unchanged on both or neither. count is never driven outside 0..DEPTH.
- Group ordering is strictly FIFO. Lane k of a stored group is always output on data_outk.

## Timing
- Reset (reset_L=0, asynchronous): data_out0..3=0, valid_out=0, src=0, count=0, fifo_empty=1, fifo_full=0, overflow=0, both pointers 0. Storage contents are don't-care.
- Latency: 1 clock from an input sample (live or FIFO head) to data_out*/valid_out/src.
- fifo_full, fifo_empty and count reflect the registered state and update on the edge after a push or pop.
- Reset asserted mid-replay: any in-flight stored groups are discarded. The first cycle after release is IDLE unless validIn=1.
- Wrap-around: the pointers wrap DEPTH−1 → 0. Full and empty are distinguished by count, not by pointer equality.

## Structure
- A shared package `recirc_pkg` holds:
  - the SRC_IDLE / SRC_LIVE / SRC_REPLAY encodings;
  - a `lane_group_t` packed struct of 4 × DATA_W;
  - the default DEPTH.
- One sub-module, `recirc_fifo`: a parameterised synchronous FIFO with push, pop, head, count, full and empty, reset to empty. The top level contains only the selection FSM, the output registers and the overflow flag.

## Test plan
- Reset check: hold reset_L=0 with random inputs. All outputs at their reset values. Release with validIn=0, rec_valid=0 → valid_out=0, src=0 indefinitely.
- Live priority: validIn=1 with In0..3 = 0x11, 0x22, 0x33, 0x44 while the FIFO holds one group 0xA0..0xA3 → next cycle data_out = 0x11..0x44, src=1, count stays 1. Drop validIn → following cycle data_out = 0xA0..0xA3, src=2, count=0.
- Fill and overflow (DEPTH=4): push 5 groups 0x01..0x05 (in lane 0) with validIn=1. After the 4th push fifo_full=1 and rec_ready=0; the 5th group is dropped and overflow=1. Then validIn=0 → replay order 0x01, 0x02, 0x03, 0x04, then IDLE. overflow remains 1.
- Simultaneous push/pop: count=2, validIn=0, rec_valid=1 for 6 cycles → count stays 2, pointers wrap, output order matches push order.
- Empty push, no bypass: count=0, validIn=0, push 0x5A → data_out=0 and valid_out=0 on that edge. The next edge replays 0x5A with src=2.
- Reset mid-replay: count=3, assert reset_L=0 asynchronously between edges → outputs are zero immediately and count=0. After release, no stale group is replayed.
